// File: rtl/seq_chunk_adder.sv
// Multi-cycle unsigned adder: in1 + in2 + cin over WIDTH bits, CHUNK bits per clock.
// Define SEQ_ADDER_SATURATE_EN to clamp sum to all ones on carry-out.
module seq_chunk_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned N    = WIDTH / CHUNK;
   localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state_q, state_nxt;
   logic [WIDTH-1:0]  a_q, b_q;
   logic              carry_q;
   logic [IDXW-1:0]   idx_q;
   logic [CHUNK:0]    chunk_sum;
   int unsigned       lo;
   logic              accept, last;
   logic              in_ready_nxt, out_valid_nxt;

   // One chunk of the add; the MSB becomes the next running carry
   always_comb begin
      lo        = 32'(idx_q) * CHUNK;
      chunk_sum = {1'b0, a_q[lo +: CHUNK]} + {1'b0, b_q[lo +: CHUNK]} + (CHUNK+1)'(carry_q);
   end

   assign accept = (state_q == IDLE) && in_valid && in_ready;
   assign last   = (idx_q == IDXW'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:    if (accept)    state_nxt = CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake flags are registered from the upcoming state
   always_comb begin
      in_ready_nxt  = 1'b0;
      out_valid_nxt = 1'b0;
      if (state_nxt == IDLE) in_ready_nxt  = 1'b1;
      if (state_nxt == DONE) out_valid_nxt = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
      end else begin
         in_ready  <= in_ready_nxt;
         out_valid <= out_valid_nxt;
         if (accept) begin
            a_q     <= in1;
            b_q     <= in2;
            carry_q <= cin;
            idx_q   <= '0;
         end
         if (state_q == CALC) begin
            sum[lo +: CHUNK] <= chunk_sum[CHUNK-1:0];
            carry_q          <= chunk_sum[CHUNK];
            idx_q            <= idx_q + IDXW'(1);
            if (last) begin
               cout <= chunk_sum[CHUNK];
`ifdef SEQ_ADDER_SATURATE_EN
               if (chunk_sum[CHUNK]) sum <= '1;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: table vectors, handshake/reset sequences and
// randomized adds against an arithmetic reference, on three parameter sets.
module tb_seq_chunk_adder;

   logic clk, rst_n;
   logic [1:0]  sel;
   logic        iv, ordy, c;
   logic [63:0] a, b;

   logic ir32, ov32, co32, ir16, ov16, co16, ir64, ov64, co64;
   logic [31:0] s32;
   logic [15:0] s16;
   logic [63:0] s64;

   logic        cur_ir, cur_ov, cur_co;
   logic [63:0] cur_sum;

   int n_vec, n_err;

   seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd0), .in_ready(ir32),
      .in1(a[31:0]), .in2(b[31:0]), .cin(c), .out_valid(ov32),
      .out_ready(ordy && sel == 2'd0), .sum(s32), .cout(co32));

   seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd1), .in_ready(ir16),
      .in1(a[15:0]), .in2(b[15:0]), .cin(c), .out_valid(ov16),
      .out_ready(ordy && sel == 2'd1), .sum(s16), .cout(co16));

   seq_chunk_adder #(.WIDTH(64), .CHUNK(1)) u64 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2'd2), .in_ready(ir64),
      .in1(a), .in2(b), .cin(c), .out_valid(ov64),
      .out_ready(ordy && sel == 2'd2), .sum(s64), .cout(co64));

   always_comb begin
      case (sel)
         2'd0:    begin cur_ir = ir32; cur_ov = ov32; cur_co = co32; cur_sum = {32'b0, s32}; end
         2'd1:    begin cur_ir = ir16; cur_ov = ov16; cur_co = co16; cur_sum = {48'b0, s16}; end
         default: begin cur_ir = ir64; cur_ov = ov64; cur_co = co64; cur_sum = s64; end
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  sel;
      logic [63:0] a, b;
      logic        c;
      logic [63:0] es;
      logic        ec;
      int          lat;
   } vec_t;

   vec_t tbl[5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: full-width integer add, carry taken from bit WIDTH
   function automatic logic [64:0] model(input logic [1:0] s, input logic [63:0] x, y, input logic ci);
      int w;
      logic [64:0] m, full, rs;
      logic co;
      w    = (s == 2'd0) ? 32 : (s == 2'd1) ? 16 : 64;
      m    = (65'd1 << w) - 65'd1;
      full = {1'b0, x & m[63:0]} + {1'b0, y & m[63:0]} + 65'(ci);
      co   = full[w];
      rs   = full & m;
`ifdef SEQ_ADDER_SATURATE_EN
      if (co) rs = m;
`endif
      return {co, rs[63:0]};
   endfunction

   task automatic run(input logic [1:0] s, input logic [63:0] x, y, input logic ci, input int hold,
                      output logic [63:0] rs, output logic rc, output int lat);
      int t;
      sel = s; a = x; b = y; c = ci;
      #1;
      t = 0;
      while (!cur_ir && t < 200) begin @(posedge clk); #1; t++; end
      check("in_ready_idle", 64'(cur_ir), 64'd1);
      iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      a = ~x; b = ~y; c = ~ci;
      lat = 0;
      while (!cur_ov && lat < 200) begin @(posedge clk); #1; lat++; end
      rs = cur_sum; rc = cur_co;
      for (int i = 0; i < hold; i++) begin
         check("in_ready_done", 64'(cur_ir), 64'd0);
         @(posedge clk); #1;
         check("hold_valid", 64'(cur_ov), 64'd1);
         check("hold_sum", cur_sum, rs);
         check("hold_cout", 64'(cur_co), 64'(rc));
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      check("in_ready_after", 64'(cur_ir), 64'd1);
      check("out_valid_after", 64'(cur_ov), 64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] rs, x, y;
      logic [64:0] ref_v;
      logic rc, ci;
      int lat;
      n_vec = 0; n_err = 0;
      sel = 2'd0; iv = 1'b0; ordy = 1'b0; a = '0; b = '0; c = 1'b0;

      tbl[0] = '{2'd0, 64'hFFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 4};
      tbl[1] = '{2'd0, 64'h0000_00FF, 64'h1, 1'b0, 64'h100, 1'b0, 4};
      tbl[2] = '{2'd0, 64'h1234_5678, 64'h1111_1111, 1'b1, 64'h2345_678A, 1'b0, 4};
      tbl[3] = '{2'd1, 64'h8000, 64'h8000, 1'b0, 64'h0, 1'b1, 1};
      tbl[4] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 64};
`ifdef SEQ_ADDER_SATURATE_EN
      tbl[0].es = 64'hFFFF_FFFF;
      tbl[3].es = 64'hFFFF;
      tbl[4].es = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(ir32), 64'd0);
      check("rst_out_valid", 64'(ov32), 64'd0);
      check("rst_sum", 64'(s32), 64'd0);
      check("rst_cout", 64'(co32), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rel_in_ready", 64'(ir32), 64'd1);

      for (int i = 0; i < 5; i++) begin
         run(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].c, 0, rs, rc, lat);
         check($sformatf("tbl%0d_sum", i), rs, tbl[i].es);
         check($sformatf("tbl%0d_cout", i), 64'(rc), 64'(tbl[i].ec));
         check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      end

      // Back-pressure for 5 cycles, then a second transaction
      run(2'd0, 64'h8000_0001, 64'h7FFF_FFFF, 1'b0, 5, rs, rc, lat);
      check("bp_sum", rs, 64'h0);
      check("bp_cout", 64'(rc), 64'd1);
      run(2'd0, 64'h0000_1000, 64'h0000_0234, 1'b0, 0, rs, rc, lat);
      check("bp2_sum", rs, 64'h1234);
      check("bp2_cout", 64'(rc), 64'd0);

      // Reset two edges after accept
      sel = 2'd0; a = 64'hAAAA_5555; b = 64'h1111_2222; c = 1'b1;
      #1;
      iv = 1'b1;
      @(posedge clk); #1;
      iv = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valid", 64'(ov32), 64'd0);
      check("mid_rst_sum", 64'(s32), 64'd0);
      check("mid_rst_cout", 64'(co32), 64'd0);
      check("mid_rst_ready", 64'(ir32), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("mid_rel_ready", 64'(ir32), 64'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check("mid_no_result", 64'(ov32), 64'd0);
      end
      run(2'd0, 64'hDEAD_BEEF, 64'h0101_0101, 1'b1, 0, rs, rc, lat);
      ref_v = model(2'd0, 64'hDEAD_BEEF, 64'h0101_0101, 1'b1);
      check("post_rst_sum", rs, ref_v[63:0]);
      check("post_rst_cout", 64'(rc), 64'(ref_v[64]));

      // Random vectors: default build and the 64/1 configuration
      for (int i = 0; i < 200; i++) begin
         x = {32'b0, $urandom}; y = {32'b0, $urandom}; ci = 1'($urandom);
         run(2'd0, x, y, ci, 0, rs, rc, lat);
         ref_v = model(2'd0, x, y, ci);
         check("rnd32_sum", rs, ref_v[63:0]);
         check("rnd32_cout", 64'(rc), 64'(ref_v[64]));
         check("rnd32_lat", 64'(lat), 64'd4);
      end
      for (int i = 0; i < 1000; i++) begin
         x = {$urandom, $urandom}; y = {$urandom, $urandom}; ci = 1'($urandom);
         run(2'd2, x, y, ci, 0, rs, rc, lat);
         ref_v = model(2'd2, x, y, ci);
         check("rnd64_sum", rs, ref_v[63:0]);
         check("rnd64_cout", 64'(rc), 64'(ref_v[64]));
         check("rnd64_lat", 64'(lat), 64'd64);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
